// File: rtl/flexsoc_irq_pkg.sv
// Shared constants for the AHB3-lite interrupt controller: register offsets
// (HADDR[4:2]) and the slave response state encoding.
package flexsoc_irq_pkg;

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_SET    = 3'd2;
  localparam logic [2:0] OFF_CLR    = 3'd3;
  localparam logic [2:0] OFF_EDGE   = 3'd4;
  localparam logic [2:0] OFF_ID     = 3'd5;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    RESP_OKAY = 2'd0,
    RESP_ERR1 = 2'd1,
    RESP_ERR2 = 2'd2
  } resp_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for asynchronous level inputs.
module sync_ff #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/ahb3lite_irq_ctrl.sv
// AHB3-lite interrupt controller: synchronised sources latch into pend, gated by
// enable to drive the core interrupt vector. Zero-wait word access, two-cycle ERROR otherwise.
module ahb3lite_irq_ctrl
  import flexsoc_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h1A0C0001
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [3:0]         HPROT,
  input  logic [1:0]         HTRANS,
  input  logic               HREADY,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [NUM_IRQ-1:0] irq
);

  resp_e              resp_q, resp_d;
  logic [2:0]         addr_q, addr_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] src_d_q;
  logic [NUM_IRQ-1:0] src_s;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] sw_set, sw_clr, hw_set;
  logic               accept;

  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:5], HADDR[1:0], HWDATA, HBURST, HPROT, HTRANS[0]};

  sync_ff #(
    .Width  (NUM_IRQ),
    .Stages (SYNC_STAGES)
  ) u_sync (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .d_i    (irq_src),
    .q_o    (src_s)
  );

  assign accept = HSEL & HREADY & HTRANS[1];
  assign wdata  = HWDATA[NUM_IRQ-1:0];

  // Address phase capture and response sequencing.
  always_comb begin
    resp_d = RESP_OKAY;
    addr_d = addr_q;
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    unique case (resp_q)
      RESP_ERR1: resp_d = RESP_ERR2;
      default: begin
        if (accept) begin
          if (HSIZE == HSIZE_WORD) begin
            addr_d = HADDR[4:2];
            wr_d   = HWRITE;
            rd_d   = ~HWRITE;
          end else begin
            resp_d = RESP_ERR1;
          end
        end
      end
    endcase
  end

  // Data phase writes; a hardware set on a bit overrides a same-cycle CLR.
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    sw_set   = '0;
    sw_clr   = '0;
    if (wr_q) begin
      case (addr_q)
        OFF_ENABLE: enable_d = wdata;
        OFF_SET:    sw_set   = wdata;
        OFF_CLR:    sw_clr   = wdata;
        OFF_EDGE:   edge_d   = wdata;
        default:    ;
      endcase
    end
    hw_set = (edge_q & src_s & ~src_d_q) | (~edge_q & src_s);
    pend_d = (pend_q & ~sw_clr) | sw_set | hw_set;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      resp_q   <= RESP_OKAY;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      pend_q   <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      src_d_q  <= '0;
    end else begin
      resp_q   <= resp_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      src_d_q  <= src_s;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      case (addr_q)
        OFF_STATUS: HRDATA = 32'(pend_q);
        OFF_ENABLE: HRDATA = 32'(enable_q);
        OFF_EDGE:   HRDATA = 32'(edge_q);
        OFF_ID:     HRDATA = ID_VALUE;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = (resp_q != RESP_ERR1);
  assign HRESP     = (resp_q != RESP_OKAY);
  assign irq       = pend_q & enable_q;

endmodule

// File: tb/tb_ahb3lite_irq_ctrl.sv
// Randomised and directed bench for ahb3lite_irq_ctrl, checked every cycle
// against a behavioural model of the register map and interrupt latching.
module tb_ahb3lite_irq_ctrl;

  localparam int N  = 16;
  localparam int SS = 2;
  localparam logic [31:0] IDV = 32'h1A0C0001;

  logic          CLK, RESETn;
  logic          HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic [N-1:0]  irq_src, irq;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  assign HREADY = HREADYOUT;

  ahb3lite_irq_ctrl #(
    .NUM_IRQ     (N),
    .SYNC_STAGES (SS),
    .ID_VALUE    (IDV)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .irq_src   (irq_src),
    .irq       (irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file, source sample history, pending data phase.
  logic [N-1:0] m_pend, m_en, m_edge;
  logic [N-1:0] m_hist [0:SS];
  logic         m_dp_wr, m_dp_rd;
  logic [2:0]   m_dp_off;
  logic [1:0]   m_err;  // error cycles still to present

  function automatic logic [N-1:0] next_pend(input logic [N-1:0] pend, input logic [N-1:0] edm,
                                             input logic [N-1:0] s, input logic [N-1:0] d,
                                             input logic [N-1:0] sset, input logic [N-1:0] sclr);
    logic [N-1:0] r;
    logic hw;
    for (int i = 0; i < N; i++) begin
      hw = edm[i] ? (s[i] && !d[i]) : s[i];
      if (hw || sset[i]) r[i] = 1'b1;
      else if (sclr[i])  r[i] = 1'b0;
      else               r[i] = pend[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0:    return 32'(m_pend);
      3'd1:    return 32'(m_en);
      3'd4:    return 32'(m_edge);
      3'd5:    return IDV;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_pend   <= '0;
      m_en     <= '0;
      m_edge   <= '0;
      m_dp_wr  <= 1'b0;
      m_dp_rd  <= 1'b0;
      m_dp_off <= 3'd0;
      m_err    <= 2'd0;
      for (int i = 0; i <= SS; i++) m_hist[i] <= '0;
    end else begin
      m_pend <= next_pend(m_pend, m_edge, m_hist[SS-1], m_hist[SS],
                          (m_dp_wr && m_dp_off == 3'd2) ? HWDATA[N-1:0] : '0,
                          (m_dp_wr && m_dp_off == 3'd3) ? HWDATA[N-1:0] : '0);
      if (m_dp_wr && m_dp_off == 3'd1) m_en   <= HWDATA[N-1:0];
      if (m_dp_wr && m_dp_off == 3'd4) m_edge <= HWDATA[N-1:0];
      m_hist[0] <= irq_src;
      for (int i = 1; i <= SS; i++) m_hist[i] <= m_hist[i-1];
      m_dp_wr <= 1'b0;
      m_dp_rd <= 1'b0;
      if (m_err == 2'd2) begin
        m_err <= 2'd1;
      end else begin
        if (m_err == 2'd1) m_err <= 2'd0;
        if (HSEL && HTRANS[1]) begin
          if (HSIZE == 3'd2) begin
            m_dp_wr  <= HWRITE;
            m_dp_rd  <= !HWRITE;
            m_dp_off <= HADDR[4:2];
          end else begin
            m_err <= 2'd2;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("irq", 32'(irq), 32'(m_pend & m_en));
      chk("hrdata", HRDATA, m_dp_rd ? m_read(m_dp_off) : 32'h0);
      chk("hreadyout", 32'(HREADYOUT), 32'(m_err != 2'd2));
      chk("hresp", 32'(HRESP), 32'(m_err != 2'd0));
    end
  end

  task automatic drive_addr(input bit wr, input logic [31:0] addr, input logic [2:0] size);
    HSEL   = 1'b1;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = 2'b10;
    HBURST = 3'd0;
    HPROT  = 4'h3;
  endtask

  // Called at a negedge; returns at the negedge of the final data-phase cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] size, output logic [31:0] rd);
    int n;
    drive_addr(wr, addr, size);
    @(negedge CLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wd;
    rd     = HRDATA;
    n = 0;
    while (!HREADYOUT && n < 4) begin
      @(negedge CLK);
      n++;
    end
    chk("xfer_ready", 32'(HREADYOUT), 32'd1);
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] rd;
    xfer(1'b1, {27'h0, off, 2'b00}, wd, 3'd2, rd);
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [31:0] rd);
    xfer(1'b0, {27'h0, off, 2'b00}, 32'h0, 3'd2, rd);
  endtask

  logic [31:0] rdata, addr, wd;
  logic [2:0]  off, sz;
  bit          wr;

  initial begin
    RESETn = 1'b1;
    HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = '0; HPROT = '0; HTRANS = 2'b00; irq_src = '0;
    #1 RESETn = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0);
    #2 RESETn = 1'b1;
    chk_en = 1'b1;
    @(negedge CLK);

    // SET/ENABLE gating, STATUS and ID readback.
    wr_reg(3'd2, 32'h8001);
    wr_reg(3'd1, 32'h0001);
    @(negedge CLK);
    chk("set_en_irq", 32'(irq), 32'h0001);
    rd_reg(3'd0, rdata);
    chk("status_8001", rdata, 32'h8001);
    rd_reg(3'd5, rdata);
    chk("id", rdata, 32'h1A0C0001);
    rd_reg(3'd6, rdata);
    chk("off6_zero", rdata, 32'h0);

    // Edge-mode pulse on bit 3, then clear.
    wr_reg(3'd3, 32'hFFFF);
    wr_reg(3'd4, 32'h0008);
    wr_reg(3'd1, 32'h0008);
    @(negedge CLK);
    irq_src[3] = 1'b1;
    @(negedge CLK);
    irq_src[3] = 1'b0;
    chk("edge_e1", 32'(irq), 32'h0);
    @(negedge CLK);
    chk("edge_e2", 32'(irq), 32'h0);
    @(negedge CLK);
    chk("edge_e3", 32'(irq), 32'h0008);
    wr_reg(3'd3, 32'h0008);
    chk("clr_dphase", 32'(irq), 32'h0008);
    @(negedge CLK);
    chk("clr_after", 32'(irq), 32'h0);

    // Level mode: CLR ineffective while source held.
    wr_reg(3'd4, 32'h0);
    irq_src[0] = 1'b1;
    repeat (4) @(negedge CLK);
    wr_reg(3'd3, 32'h0001);
    rd_reg(3'd0, rdata);
    chk("level_held", rdata, 32'h0001);
    irq_src[0] = 1'b0;
    repeat (4) @(negedge CLK);
    wr_reg(3'd3, 32'h0001);
    rd_reg(3'd0, rdata);
    chk("level_cleared", rdata, 32'h0);

    // Byte write to ENABLE: two-cycle ERROR, ENABLE unchanged.
    drive_addr(1'b1, 32'h4, 3'd0);
    @(negedge CLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFF;
    chk("err1_ready", 32'(HREADYOUT), 32'd0);
    chk("err1_resp", 32'(HRESP), 32'd1);
    @(negedge CLK);
    chk("err2_ready", 32'(HREADYOUT), 32'd1);
    chk("err2_resp", 32'(HRESP), 32'd1);
    rd_reg(3'd1, rdata);
    chk("enable_kept", rdata, 32'h0008);

    // Edge set on bit 5 coinciding with CLR of bit 5.
    wr_reg(3'd4, 32'h0020);
    wr_reg(3'd1, 32'h0020);
    irq_src[5] = 1'b1;
    @(negedge CLK);
    wr_reg(3'd3, 32'h0020);
    rd_reg(3'd0, rdata);
    chk("hw_wins", rdata, 32'h0020);
    chk("hw_wins_irq", 32'(irq), 32'h0020);

    // Reset during the first ERROR cycle.
    drive_addr(1'b1, 32'h4, 3'd1);
    @(negedge CLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("pre_rst_err1", 32'(HREADYOUT), 32'd0);
    #2 RESETn = 1'b0;
    #1;
    chk("rst_err_ready", 32'(HREADYOUT), 32'd1);
    chk("rst_err_resp", 32'(HRESP), 32'd0);
    chk("rst_err_irq", 32'(irq), 32'h0);
    chk("rst_err_hrdata", HRDATA, 32'h0);
    repeat (2) @(negedge CLK);
    #2 RESETn = 1'b1;
    @(negedge CLK);

    // Randomised traffic against the model.
    for (int it = 0; it < 900; it++) begin
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ N'(32'd1 << $urandom_range(0, N-1));
      if ($urandom_range(0, 9) <= 6) begin
        off  = 3'($urandom_range(0, 7));
        wr   = 1'($urandom_range(0, 1));
        sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
        addr = $urandom;
        addr[4:2] = off;
        wd   = $urandom;
        xfer(wr, addr, wd, sz, rdata);
      end else begin
        HSEL   = 1'($urandom_range(0, 1));
        HTRANS = HSEL ? ($urandom_range(0, 1) ? 2'b01 : 2'b00) : 2'b10;
        HADDR  = $urandom;
        HWRITE = 1'b1;
        HSIZE  = 3'd2;
        @(negedge CLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
      end
    end
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
